lcd_hd44780_ctrl: RTL



---
 rtl/lcd_hd44780_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit write controller: autonomous power-up init, then one byte per valid/ready handshake.
// Optional LCD_BUSY_POLL_EN replaces the post-init fixed execution delay with a busy-flag poll.
module lcd_hd44780_ctrl #(
  parameter int unsigned T_POWERUP   = 2000000,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_EN_HIGH   = 25,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 2500,
  parameter int unsigned T_EXEC_LONG = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       init_done,
  output logic       busy,
  output logic       EN,
  output logic       RS,
  output logic       RW,
  output logic [7:0] data
`ifdef LCD_BUSY_POLL_EN
  ,
  input  logic [7:0] data_in,
  output logic       data_oe
`endif
);

  typedef enum logic [2:0] {StPowerup, StSetup, StEnHi, StHold, StWait, StIdle} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  step_q, step_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        init_done_q, init_done_d;
  logic        en_q, en_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic [31:0] wait_len;
`ifdef LCD_BUSY_POLL_EN
  logic        rw_q, rw_d;
  logic        oe_q, oe_d;
  logic        poll_q, poll_d;
  logic        bf_q, bf_d;
`endif

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: init_rom = 8'h38;
      3'd4:                   init_rom = 8'h0C;
      3'd5:                   init_rom = 8'h01;
      default:                init_rom = 8'h06;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    step_d      = step_q;
    rs_d        = rs_q;
    data_d      = data_q;
    init_done_d = init_done_q;
`ifdef LCD_BUSY_POLL_EN
    rw_d        = rw_q;
    oe_d        = oe_q;
    poll_d      = poll_q;
    bf_d        = bf_q;
`endif
    // Clear Display and Return Home need the long execution delay
    wait_len = (!rs_q && (data_q inside {8'h01, 8'h02, 8'h03})) ? T_EXEC_LONG : T_EXEC;

    case (state_q)
      StPowerup: begin
        if (cnt_q == T_POWERUP - 1) begin
          cnt_d   = '0;
          step_d  = '0;
          rs_d    = 1'b0;
          data_d  = init_rom(3'd0);
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == T_SETUP - 1) begin
          cnt_d   = '0;
          state_d = StEnHi;
        end
      end
      StEnHi: begin
        if (cnt_q == T_EN_HIGH - 1) begin
          cnt_d   = '0;
          state_d = StHold;
`ifdef LCD_BUSY_POLL_EN
          if (poll_q) bf_d = data_in[7];
`endif
        end
      end
      StHold: begin
        if (cnt_q == T_HOLD - 1) begin
          cnt_d   = '0;
          state_d = StWait;
`ifdef LCD_BUSY_POLL_EN
          if (init_done_q) begin
            if (poll_q && !bf_q) begin
              state_d = StIdle;
              poll_d  = 1'b0;
              rw_d    = 1'b0;
              oe_d    = 1'b1;
            end else begin
              state_d = StSetup;
              poll_d  = 1'b1;
              rw_d    = 1'b1;
              oe_d    = 1'b0;
              rs_d    = 1'b0;
            end
          end
`endif
        end
      end
      StWait: begin
        if (cnt_q == wait_len - 32'd1) begin
          cnt_d = '0;
          if (init_done_q) begin
            state_d = StIdle;
          end else if (step_q == 3'd6) begin
            init_done_d = 1'b1;
            state_d     = StIdle;
          end else begin
            step_d  = step_q + 3'd1;
            rs_d    = 1'b0;
            data_d  = init_rom(step_q + 3'd1);
            state_d = StSetup;
          end
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (wr_valid && ready_q) begin
          rs_d    = wr_rs;
          data_d  = wr_data;
          state_d = StSetup;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StPowerup;
      end
    endcase

    en_d    = (state_d == StEnHi);
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle) && init_done_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StPowerup;
      cnt_q       <= '0;
      step_q      <= '0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
      en_q        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
`ifdef LCD_BUSY_POLL_EN
      rw_q        <= 1'b0;
      oe_q        <= 1'b1;
      poll_q      <= 1'b0;
      bf_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      en_q        <= en_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
`ifdef LCD_BUSY_POLL_EN
      rw_q        <= rw_d;
      oe_q        <= oe_d;
      poll_q      <= poll_d;
      bf_q        <= bf_d;
`endif
    end
  end

  assign wr_ready  = ready_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;
  assign EN        = en_q;
  assign RS        = rs_q;
  assign data      = data_q;
`ifdef LCD_BUSY_POLL_EN
  assign RW        = rw_q;
  assign data_oe   = oe_q;
`else
  assign RW        = 1'b0;
`endif

endmodule
